// File: rtl/fetch.sv
// fetch -- instruction-fetch stage; owns the PC and fills the F/D register.
//
// Talks to instruction memory through a request/ready handshake. Delivers
// {valid, pc_plus_2, instruction} to decode on F_out. Obeys decode's
// flush/branch_target, stall and halt inputs.
//
// Optional macro: FETCH_SKID_BUF_EN
//   If defined, the stage keeps requesting while stall is high. A word that is
//   accepted during the stall goes into a one-entry buffer.
//   If undefined, the request drops during stall and the same PC is fetched
//   again once the stall clears.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   stall               decode holds; F_out and PC hold
//   flush/branch_target redirect (only honoured while F_out is valid)
//   halt                HLT in decode (only honoured while F_out is valid)
//   imem_req/addr       fetch request, address == PC
//   imem_ready/data     memory response for the current address
//   F_out               [32] valid, [31:16] PC+2, [15:0] instruction
//   pc_out              current PC
//   halted              fetch permanently stopped until reset
module fetch #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [15:0] BUBBLE_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] branch_target,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [32:0] F_out,
  output logic [15:0] pc_out,
  output logic        halted
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALT} state_e;

  localparam logic [32:0] BUBBLE = {1'b0, 16'h0000, BUBBLE_INSTR};

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [32:0] fout_q, fout_d;
`ifdef FETCH_SKID_BUF_EN
  logic [15:0] buf_q, buf_d;
`endif

  logic [15:0] pc_plus2;
  logic        accept, qflush, qhalt;

  assign pc_plus2  = pc_q + 16'd2;   // wraps modulo 2^16
  assign accept    = imem_req & imem_ready;
  // Decode's control outputs only mean something while it holds a real instruction.
  assign qflush    = flush & fout_q[32];
  assign qhalt     = halt & fout_q[32];

  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign F_out     = fout_q;
  assign halted    = (state_q == S_HALT);

  always_comb begin
    imem_req = 1'b0;
    if (!rst && state_q == S_FETCH) begin
`ifdef FETCH_SKID_BUF_EN
      imem_req = 1'b1;
`else
      imem_req = ~stall;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fout_d  = fout_q;
`ifdef FETCH_SKID_BUF_EN
    buf_d   = buf_q;
`endif
    if (qflush) begin
      // A redirect drops the buffer and any fetch in flight.
      pc_d    = {branch_target[15:1], 1'b0};
      fout_d  = BUBBLE;
      state_d = S_FETCH;
    end else if (state_q == S_HALT) begin
      fout_d  = BUBBLE;
    end else if (stall) begin
`ifdef FETCH_SKID_BUF_EN
      if (state_q == S_FETCH && accept) begin
        buf_d   = imem_data;
        state_d = S_HOLD;
      end
`endif
    end else if (qhalt) begin
      fout_d  = BUBBLE;
      state_d = S_HALT;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (accept) begin
            fout_d = {1'b1, pc_plus2, imem_data};
            pc_d   = pc_plus2;
          end else begin
            fout_d = BUBBLE;
          end
        end
        S_HOLD: begin
`ifdef FETCH_SKID_BUF_EN
          fout_d = {1'b1, pc_plus2, buf_q};
          pc_d   = pc_plus2;
`endif
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      fout_q  <= BUBBLE;
`ifdef FETCH_SKID_BUF_EN
      buf_q   <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fout_q  <= fout_d;
`ifdef FETCH_SKID_BUF_EN
      buf_q   <= buf_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch. Memory returns mem[a] = a ^ 16'h1111; readiness
// is driven directly by the stimulus.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst, stall, flush, halt, imem_ready;
  logic [15:0] branch_target, imem_addr, imem_data, pc_out;
  logic        imem_req, halted;
  logic [32:0] F_out;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [32:0] BUB = 33'h0;

  always #5 clk = ~clk;

  assign imem_data = imem_addr ^ 16'h1111;

  fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_target(branch_target), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .F_out(F_out), .pc_out(pc_out), .halted(halted)
  );

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; halt = 0; imem_ready = 1; branch_target = 16'h0;
    #1;
    chk("req_in_reset", {32'h0, imem_req}, 33'd0);
    step();
    chk("rst_fout", F_out, BUB);
    chk("rst_pc", {17'h0, pc_out}, 33'h0);
    chk("rst_halted", {32'h0, halted}, 33'd0);
    chk("rst_req", {32'h0, imem_req}, 33'd0);
    rst = 0; #1;
    chk("req_after_rst", {32'h0, imem_req}, 33'd1);
    chk("addr0", {17'h0, imem_addr}, 33'h0);

    // 1: zero-wait streaming
    step(); chk("stream0", F_out, {1'b1, 16'h0002, 16'h1111});
    step(); chk("stream1", F_out, {1'b1, 16'h0004, 16'h1113});
    step(); chk("stream2", F_out, {1'b1, 16'h0006, 16'h1115});

    // 2: wait states at 0x0010 (reached through a flush)
    flush = 1; branch_target = 16'h0010; imem_ready = 0;
    step(); flush = 0;
    chk("ws_addr0", {17'h0, imem_addr}, {17'h0, 16'h0010});
    chk("ws_bub0", F_out, BUB);
    step();
    chk("ws_addr1", {17'h0, imem_addr}, {17'h0, 16'h0010});
    chk("ws_bub1", F_out, BUB);
    imem_ready = 1;
    step(); chk("ws_data", F_out, {1'b1, 16'h0012, 16'h1101});

    // 3: stall across an accept at 0x0020
    flush = 1; branch_target = 16'h0020;
    step(); flush = 0;
    chk("st_addr", {17'h0, imem_addr}, {17'h0, 16'h0020});
    stall = 1; #1;
`ifdef FETCH_SKID_BUF_EN
    chk("st_req_first", {32'h0, imem_req}, 33'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_req_hold", {32'h0, imem_req}, 33'd0);
      chk("st_fout_hold", F_out, BUB);
    end
`else
    for (int i = 0; i < 3; i++) begin
      chk("st_req_low", {32'h0, imem_req}, 33'd0);
      step();
      chk("st_fout_hold", F_out, BUB);
      chk("st_pc_hold", {17'h0, pc_out}, {17'h0, 16'h0020});
    end
`endif
    stall = 0; #1;
`ifndef FETCH_SKID_BUF_EN
    chk("st_rereq", {16'h0, imem_req, imem_addr}, {16'h0, 1'b1, 16'h0020});
`endif
    step();
    chk("st_release", F_out, {1'b1, 16'h0022, 16'h1131});
    chk("st_next_addr", {16'h0, imem_req, imem_addr}, {16'h0, 1'b1, 16'h0022});

    // 4: flush while waiting; bit 0 of the target is dropped
    imem_ready = 0; flush = 1; branch_target = 16'h0041;
    step(); flush = 0;
    chk("fl_addr", {17'h0, imem_addr}, {17'h0, 16'h0040});
    chk("fl_bub", F_out, BUB);
    imem_ready = 1;
    step(); chk("fl_data", F_out, {1'b1, 16'h0042, 16'h1151});
    imem_ready = 0;
    step(); chk("fl_wait_bub", F_out, BUB);
    flush = 1; branch_target = 16'h0080;
    step(); flush = 0;
    chk("fl_ignored", {17'h0, pc_out}, {17'h0, 16'h0042});

    // 5: halt deferred by stall, then taken
    imem_ready = 1;
    step(); chk("h_valid", F_out, {1'b1, 16'h0044, 16'h1153});
    halt = 1; stall = 1;
    step(); chk("h_deferred", {32'h0, halted}, 33'd0);
    stall = 0;
    step(); halt = 0;
    chk("h_halted", {32'h0, halted}, 33'd1);
    chk("h_req", {32'h0, imem_req}, 33'd0);
    chk("h_pc", {17'h0, pc_out}, {17'h0, 16'h0044});
    chk("h_fout", F_out, BUB);
    flush = 1; branch_target = 16'h0080;
    step(); flush = 0;
    chk("h_flush_ign_pc", {17'h0, pc_out}, {17'h0, 16'h0044});
    chk("h_flush_ign_halt", {32'h0, halted}, 33'd1);

    // 6: reset from halt, wrap, reset mid-wait
    rst = 1;
    step(); rst = 0;
    chk("rh_pc", {17'h0, pc_out}, 33'h0);
    chk("rh_fout", F_out, BUB);
    chk("rh_halted", {32'h0, halted}, 33'd0);
    step(); chk("rh_stream", F_out, {1'b1, 16'h0002, 16'h1111});
    flush = 1; branch_target = 16'hFFFE;
    step(); flush = 0;
    step();
    chk("wrap_fout", F_out, {1'b1, 16'h0000, 16'hEEEF});
    chk("wrap_addr", {17'h0, imem_addr}, 33'h0);
    step(); chk("wrap_next", F_out, {1'b1, 16'h0002, 16'h1111});
    imem_ready = 0;
    step(); chk("mw_pc", {17'h0, pc_out}, {17'h0, 16'h0002});
    rst = 1;
    step(); rst = 0;
    chk("mw_rst_pc", {17'h0, pc_out}, 33'h0);
    chk("mw_rst_fout", F_out, BUB);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
